// File: rtl/fft_ctrl_pkg.sv
// Shared types and width helpers for the radix-2 FFT stage sequencer and its bus.
package fft_ctrl_pkg;

  localparam int LOG2_NS_MIN = 3;
  localparam int LOG2_NS_MAX = 6;
  localparam int BF_LAT_MIN  = 1;
  localparam int BF_LAT_MAX  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } fsm_state_t;

  function automatic int stg_w(input int log2_ns);
    int w;
    w = $clog2(log2_ns);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int addr_w(input int log2_ns);
    return log2_ns;
  endfunction

  function automatic int tw_w(input int log2_ns);
    return log2_ns - 1;
  endfunction

  function automatic int cnt_w(input int bf_lat);
    return (bf_lat > 1) ? $clog2(bf_lat) : 1;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Host handshake, butterfly issue and write-back signals of the FFT stage sequencer.
interface fft_stage_sequencer_if #(
  parameter int LOG2_NS = 3
);
  import fft_ctrl_pkg::*;

  localparam int STG_W = stg_w(LOG2_NS);
  localparam int AW    = addr_w(LOG2_NS);
  localparam int TW_W  = tw_w(LOG2_NS);

  logic             start;
  logic             busy;
  logic             done;
  logic             bf_valid;
  logic             bf_ready;
  logic [AW-1:0]    addr_a;
  logic [AW-1:0]    addr_b;
  logic [TW_W-1:0]  tw_idx;
  logic [STG_W-1:0] stage;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr_a;
  logic [AW-1:0]    wb_addr_b;

  modport master (
    input  start, bf_ready,
    output busy, done, bf_valid, addr_a, addr_b, tw_idx, stage,
           wb_valid, wb_addr_a, wb_addr_b
  );

  modport slave (
    output start, bf_ready,
    input  busy, done, bf_valid, addr_a, addr_b, tw_idx, stage,
           wb_valid, wb_addr_a, wb_addr_b
  );

endinterface

// File: rtl/fft_wb_delay.sv
// Fixed-depth valid+payload shift register matching the butterfly pipeline latency.
module fft_wb_delay #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  output logic         dly_valid,
  output logic [W-1:0] dly_data
);

  logic         vld_q  [DEPTH];
  logic [W-1:0] data_q [DEPTH];

  // NOTE: this is a short control pipeline, not a RAM, so every entry is reset;
  // stale valids after reset would fire spurious write-backs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= src_valid;
      data_q[0] <= src_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign dly_valid = vld_q[DEPTH-1];
  assign dly_data  = data_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Schedules LOG2_NS stages of NS/2 in-place radix-2 DIT butterflies and their
// delayed write-back addresses.
module fft_stage_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int NB      = 10,
  parameter int LOG2_NS = 3,
  parameter int NS      = 1 << LOG2_NS,
  parameter int BF_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_stage_sequencer_if.master bus
);

  localparam int STG_W = stg_w(LOG2_NS);
  localparam int AW    = addr_w(LOG2_NS);
  localparam int TW_W  = tw_w(LOG2_NS);
  localparam int K_W   = LOG2_NS - 1;
  localparam int CNT_W = cnt_w(BF_LAT);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(LOG2_NS - 1);

  if (NS != (1 << LOG2_NS) || NB < 1 ||
      LOG2_NS < LOG2_NS_MIN || LOG2_NS > LOG2_NS_MAX ||
      BF_LAT < BF_LAT_MIN || BF_LAT > BF_LAT_MAX) begin : g_bad_cfg
    $error("fft_stage_sequencer: illegal parameter combination");
  end

  fsm_state_t       state_q, state_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic run, accept;
  assign run    = (state_q == ST_RUN);
  assign accept = run && bus.bf_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every next-state signal is defaulted to its current value first so
  // no path through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          stage_d = '0;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        if (bus.bf_ready) begin
          if (&k_q) begin
            state_d = ST_DRAIN;
            k_d     = '0;
            cnt_d   = CNT_W'(BF_LAT - 1);
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Wait out the butterfly pipeline so the next stage never reads in-flight data.
        if (cnt_q == '0) begin
          if (stage_q == LAST_STAGE) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + STG_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        stage_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Butterfly k of stage s: group k>>s spans 2<<s samples, pos is the offset inside it.
  logic [AW-1:0]    k_ext, half, pos, grp, addr_a_c, addr_b_c, tw_full;
  logic [STG_W-1:0] tw_shift;

  assign k_ext    = {1'b0, k_q};
  assign half     = AW'(1) << stage_q;
  assign pos      = k_ext & (half - AW'(1));
  assign grp      = k_ext >> stage_q;
  assign addr_a_c = ((grp << stage_q) << 1) | pos;
  assign addr_b_c = addr_a_c | half;
  assign tw_shift = LAST_STAGE - stage_q;
  assign tw_full  = pos << tw_shift;

  assign bus.busy     = run || (state_q == ST_DRAIN);
  assign bus.done     = (state_q == ST_FIN);
  assign bus.bf_valid = run;
  assign bus.addr_a   = run ? addr_a_c : '0;
  assign bus.addr_b   = run ? addr_b_c : '0;
  assign bus.tw_idx   = run ? tw_full[TW_W-1:0] : '0;
  assign bus.stage    = stage_q;

  logic [2*AW-1:0] wb_src, wb_dly;
  logic            wb_vld;

  assign wb_src = accept ? {addr_a_c, addr_b_c} : '0;

  fft_wb_delay #(
    .DEPTH (BF_LAT),
    .W     (2 * AW)
  ) u_wb_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (accept),
    .src_data  (wb_src),
    .dly_valid (wb_vld),
    .dly_data  (wb_dly)
  );

  assign bus.wb_valid  = wb_vld;
  assign bus.wb_addr_a = wb_dly[2*AW-1:AW];
  assign bus.wb_addr_b = wb_dly[AW-1:0];

endmodule
